// File: rtl/fe_queue_stage.sv
// Fetch stage: walks sequential PCs over a req/ack instruction-memory port and
// buffers {pc, instruction} pairs in a QDEPTH-entry FIFO consumed by decode.
module fe_queue_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     ILEN     = 32,
    parameter int unsigned     QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_req,
    output logic [XLEN-1:0]         imem_addr,
    input  logic                    imem_ack,
    input  logic [ILEN-1:0]         imem_data,
    input  logic                    redirect,
    input  logic [XLEN-1:0]         redirect_pc,
    output logic                    out_valid,
    output logic [XLEN-1:0]         out_pc,
    output logic [ILEN-1:0]         out_isn,
    input  logic                    dec_ready,
    output logic [$clog2(QDEPTH):0] q_count
);
    localparam int unsigned   PW   = $clog2(QDEPTH);
    localparam int unsigned   CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);

    logic [XLEN-1:0] fpc_q, fpc_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [XLEN-1:0] pc_mem  [QDEPTH];
    logic [ILEN-1:0] isn_mem [QDEPTH];

    logic accept;
    logic pop;

    // Redirect drops the request, so an ack arriving with it is never accepted.
    assign imem_req  = !rst && !redirect && (count_q != FULL);
    assign imem_addr = fpc_q;
    assign accept    = imem_req && imem_ack;

    assign out_valid = (count_q != '0) && !redirect;
    assign out_pc    = pc_mem[rd_ptr_q];
    assign out_isn   = isn_mem[rd_ptr_q];
    assign pop       = out_valid && dec_ready;

    assign q_count   = count_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path leaves
        // it unassigned and no latch is inferred.
        fpc_d    = fpc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (redirect) begin
            fpc_d    = redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                fpc_d    = fpc_q + XLEN'(PC_STEP);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({accept, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q    <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            fpc_q    <= fpc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; count gates its
    // contents, and leaving it reset-free lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (accept) begin
            pc_mem[wr_ptr_q]  <= fpc_q;
            isn_mem[wr_ptr_q] <= imem_data;
        end
    end

endmodule

// File: tb/tb_fe_queue_stage.sv
// Directed bench for fe_queue_stage: the bench plays instruction memory
// (zero-wait, 3-cycle wait, or forced ack) and checks hand-computed results.
module tb_fe_queue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_isn;
    logic        dec_ready;
    logic [2:0]  q_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          mem_mode = 0;   // 0 zero-wait, 1 ack 3 cycles after req, 2 never, 3 forced ack
    int          wait_cnt = 0;
    int          n_acc;
    int          n_pop;
    logic [31:0] exp_fetch;
    logic [31:0] exp_pop;

    localparam logic [31:0] KEY = 32'hA5A5A5A5;

    fe_queue_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_isn     (out_isn),
        .dec_ready   (dec_ready),
        .q_count     (q_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_mem();
        case (mem_mode)
            0: imem_ack = imem_req;
            1: begin
                if (!imem_req) begin
                    imem_ack = 1'b0;
                    wait_cnt = 0;
                end else if (wait_cnt == 3) begin
                    imem_ack = 1'b1;
                    wait_cnt = 0;
                end else begin
                    imem_ack = 1'b0;
                    wait_cnt++;
                end
            end
            3:       imem_ack = 1'b1;
            default: imem_ack = 1'b0;
        endcase
        imem_data = imem_addr ^ KEY;
    endtask

    // One clock: controls change 1 after the edge, memory answers once req has
    // settled, and checks run 3 after the edge.
    task automatic cyc(input logic r, input logic rd, input logic [31:0] rpc, input logic dr);
        @(posedge clk);
        #1;
        rst         = r;
        redirect    = rd;
        redirect_pc = rpc;
        dec_ready   = dr;
        #1;
        drive_mem();
        #1;
    endtask

    task automatic observe_ws();
        if (imem_req && !imem_ack) check("ws_addr_hold", imem_addr, exp_fetch);
        if (imem_req && imem_ack) begin
            check("ws_accept_pc", imem_addr, exp_fetch);
            exp_fetch += 4;
            n_acc++;
        end
        if (out_valid && dec_ready) begin
            check("ws_pop_pc", out_pc, exp_pop);
            check("ws_pop_isn", out_isn, exp_pop ^ KEY);
            exp_pop += 4;
            n_pop++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
        imem_ack = 1'b0; imem_data = '0;

        // Reset state
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("rst_req", 32'(imem_req), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_count", 32'(q_count), 0);
        check("rst_addr", imem_addr, 0);

        // Zero-wait stream
        cyc(0, 0, 0, 1);
        check("c1_req", 32'(imem_req), 1);
        check("c1_addr", imem_addr, 0);
        check("c1_valid", 32'(out_valid), 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 1);
            check("st_valid", 32'(out_valid), 1);
            check("st_count", 32'(q_count), 1);
            check("st_pc", out_pc, 32'(4 * i));
            check("st_isn", out_isn, 32'(4 * i) ^ KEY);
            check("st_addr", imem_addr, 32'(4 * (i + 1)));
        end

        // Backpressure fill from empty
        cyc(1, 0, 0, 0);
        n_acc = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(0, 0, 0, 0);
            if (imem_req && imem_ack) begin
                check("bp_fill_addr", imem_addr, 32'(4 * n_acc));
                n_acc++;
            end
            if (k >= 4) begin
                check("bp_full_req", 32'(imem_req), 0);
                check("bp_full_count", 32'(q_count), 4);
            end
        end
        check("bp_accepts", 32'(n_acc), 4);
        cyc(0, 0, 0, 1);
        check("bp_p0_req", 32'(imem_req), 0);
        check("bp_p0_pc", out_pc, 32'h0);
        cyc(0, 0, 0, 1);
        check("bp_p1_req", 32'(imem_req), 1);
        check("bp_p1_addr", imem_addr, 32'h10);
        check("bp_p1_pc", out_pc, 32'h4);
        cyc(0, 0, 0, 1);
        check("bp_p2_addr", imem_addr, 32'h14);
        check("bp_p2_pc", out_pc, 32'h8);
        cyc(0, 0, 0, 1);
        check("bp_p3_pc", out_pc, 32'hC);
        cyc(0, 0, 0, 1);
        check("bp_p4_pc", out_pc, 32'h10);

        // Wait states: ack 3 cycles after each request
        mem_mode = 1; wait_cnt = 0;
        cyc(1, 0, 0, 1);
        exp_fetch = '0; exp_pop = '0; n_acc = 0; n_pop = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 0, 1);
            observe_ws();
        end
        check("ws_accepts", 32'(n_acc), 4);
        check("ws_pops", 32'(n_pop), 3);

        // Simultaneous push and pop at count 2
        mem_mode = 0;
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        check("pp0_count", 32'(q_count), 2);
        check("pp0_pc", out_pc, 32'h0);
        check("pp0_addr", imem_addr, 32'h8);
        cyc(0, 0, 0, 1);
        check("pp1_count", 32'(q_count), 2);
        check("pp1_pc", out_pc, 32'h4);
        cyc(0, 0, 0, 1);
        check("pp2_count", 32'(q_count), 2);
        check("pp2_pc", out_pc, 32'h8);
        cyc(0, 0, 0, 1);
        check("pp3_pc", out_pc, 32'hC);

        // Redirect with 3 queued, a pending request, and a same-cycle ack
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        mem_mode = 2;
        cyc(0, 0, 0, 0);
        check("rd_pend_req", 32'(imem_req), 1);
        check("rd_pend_addr", imem_addr, 32'hC);
        check("rd_pend_count", 32'(q_count), 3);
        mem_mode = 3;
        cyc(0, 1, 32'h100, 1);
        check("rd_valid", 32'(out_valid), 0);
        check("rd_req", 32'(imem_req), 0);
        mem_mode = 0;
        cyc(0, 0, 0, 0);
        check("rd_next_count", 32'(q_count), 0);
        check("rd_next_req", 32'(imem_req), 1);
        check("rd_next_addr", imem_addr, 32'h100);
        cyc(0, 0, 0, 1);
        check("rd_first_valid", 32'(out_valid), 1);
        check("rd_first_pc", out_pc, 32'h100);
        check("rd_first_isn", out_isn, 32'h100 ^ KEY);

        // Address wrap
        cyc(0, 1, 32'hFFFF_FFFC, 1);
        cyc(0, 0, 0, 1);
        check("wr_addr0", imem_addr, 32'hFFFF_FFFC);
        check("wr_count0", 32'(q_count), 0);
        cyc(0, 0, 0, 1);
        check("wr_addr1", imem_addr, 32'h0);
        check("wr_pc0", out_pc, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 1);
        check("wr_pc1", out_pc, 32'h0);

        // Reset with the queue full
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
        check("rf_count", 32'(q_count), 4);
        check("rf_req", 32'(imem_req), 0);
        cyc(1, 0, 0, 0);
        check("rf_assert_req", 32'(imem_req), 0);
        cyc(1, 0, 0, 0);
        check("rf_after_count", 32'(q_count), 0);
        check("rf_after_valid", 32'(out_valid), 0);
        check("rf_after_req", 32'(imem_req), 0);
        check("rf_after_addr", imem_addr, 32'h0);
        cyc(0, 0, 0, 0);
        check("rf_rel_req", 32'(imem_req), 1);
        check("rf_rel_addr", imem_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fe_queue_stage.md
# fe_queue_stage

Parametrised fetch stage that generates sequential fetch addresses, talks to instruction memory over a req/ack handshake, and buffers fetched {pc, instruction} pairs in a QDEPTH-entry FIFO. Decode consumes entries with valid/ready. A redirect input replaces the fetch PC and flushes all buffered and in-flight work. The block sits between the I-cache/instruction memory and decode.

## Interface
- XLEN, 32, width of PC and address.
- ILEN, 32, instruction width.
- QDEPTH, 4, fetch queue entries; power of two, ≥2.
- RESET_PC, 0, fetch PC loaded on reset.
- PC_STEP, 4, increment per fetched instruction.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address; equals fpc.
- imem_ack  in  1  memory returns imem_data this cycle; may be high in the same cycle as imem_req (zero-wait).
- imem_data  in  ILEN  instruction, valid when imem_ack=1.
- redirect  in  1  branch/exception redirect.
- redirect_pc  in  XLEN  new fetch PC, sampled when redirect=1.
- out_valid  out  1  head entry valid.
- out_pc  out  XLEN  head entry PC.
- out_isn  out  ILEN  head entry instruction.
- dec_ready  in  1  decode accepts head.
- q_count  out  $clog2(QDEPTH)+1  occupied entries.

## Operation
- State: fpc, QDEPTH×(XLEN+ILEN) storage, rd_ptr and wr_ptr (mod QDEPTH), count (0..QDEPTH).
- imem_req = !rst && !redirect && (count < QDEPTH). imem_addr = fpc.
- Accept: imem_req && imem_ack → write {fpc, imem_data} at wr_ptr, wr_ptr+1, fpc <= fpc + PC_STEP (mod 2^XLEN).
- imem_ack is ignored when imem_req=0.
- Hold rule: while imem_req=1 and no ack, imem_addr is stable. Count can only fall during the wait, so req stays high. The only exception is redirect, which drops req. The memory treats that deassertion as a cancel, and any data it later returns for the cancelled request is never accepted.
- At most one request in flight; no speculative multi-issue.
- out_valid = (count != 0) && !redirect. out_pc/out_isn = entry at rd_ptr.
- Pop: out_valid && dec_ready → rd_ptr+1.
- count update: +1 on accept only, −1 on pop only, unchanged on both or neither.
- Redirect (highest priority, below rst):
  - fpc <= redirect_pc; rd_ptr, wr_ptr, count <= 0.
  - An ack and a pop in the same cycle are both discarded.
- Full (count=QDEPTH): req low, so no push. A pop that cycle frees a slot, and req rises the next cycle.
- Empty: out_valid=0; dec_ready is don't-care.
- q_count = count.

## Timing
- Reset values: fpc=RESET_PC, pointers=0, count=0, out_valid=0, imem_req=0, q_count=0. out_pc and out_isn are don't-care while out_valid=0.
- Cycle 1 after rst deasserts: imem_req=1, imem_addr=RESET_PC.
- Fetch-to-decode latency: accept in cycle t → out_valid=1 in t+1. There is no same-cycle bypass.
- Throughput: with zero-wait memory and dec_ready=1, one instruction per cycle steady state. Queue occupancy holds at 1.
- Redirect in cycle t: imem_req=1 with imem_addr=redirect_pc in t+1 (given QDEPTH>0). First redirected instruction reaches out_valid no earlier than t+2.
- rst asserted mid-operation: all state returns to reset values the next cycle. Pending memory data is discarded.

## Test plan
- Reset and stream:
  - Stimulus: zero-wait memory returning data=addr^0xA5A5A5A5, dec_ready=1.
  - Required: out_pc sequence 0,4,8,…, out_valid from cycle 2 onward, one instruction per cycle, q_count≤1.
- Backpressure fill:
  - Stimulus: dec_ready=0 for 10 cycles, QDEPTH=4.
  - Required: exactly 4 accepts; imem_req=0 and q_count=4 thereafter.
  - Then raise dec_ready: pops of 0,4,8,C in order. imem_req rises the cycle after the first pop, and fetch resumes at 0x10.
- Wait states:
  - Stimulus: ack 3 cycles after each req.
  - Required: imem_addr stable during each wait, no duplicate or missing PCs, out_pc strictly +4.
- Redirect:
  - Stimulus: queue holds 3 entries, a request is pending, redirect=1 with redirect_pc=0x100, and ack occurs in the same cycle.
  - Required: out_valid=0 that cycle; the acked data is dropped. Next cycle q_count=0, imem_addr=0x100. First popped entry has out_pc=0x100.
- Simultaneous push/pop at count=2:
  - Stimulus: push and pop in the same cycle.
  - Required: count stays 2, FIFO order preserved.
- Wrap and reset:
  - Stimulus: redirect_pc=0xFFFFFFFC.
  - Required: next fetched PCs are 0xFFFFFFFC, then 0x00000000.
  - Stimulus: assert rst with the queue full.
  - Required: all outputs at reset values the next cycle.
